// File: rtl/ant_nav_ctrl_pkg.sv
// Shared definitions for the ant navigation controller.
// Holds the move codes, the controller state encoding and the default
// pheromone trail ID width. Imported by ant_nav_ctrl and ant_ph_tracker.
package ant_nav_ctrl_pkg;

  localparam int PH_WIDTH_DEFAULT = 4;

  typedef enum logic [1:0] {
    HALT    = 2'd0,
    RIGHT   = 2'd1,
    LEFT    = 2'd2,
    FORWARD = 2'd3
  } move_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FOLLOW = 3'd1,
    CORNER = 3'd2,
    SPIN   = 3'd3,
    DONE   = 3'd4
  } state_t;

endpackage

// File: rtl/ant_ph_tracker.sv
// Pheromone trail tracker.
// Owns the current lap ID, detects a revisit of our own trail on a forward
// move (flip_o), advances the lap ID on a flip and registers the ID to drop.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   forward_i    decided move is FORWARD in a state where a loop flip is legal
//   drop_fwd     next move is FORWARD (deposit a trail mark)
//   ph_detected  pheromone ID sensed at the current cell
//   flip_o       revisit detected this cycle (combinational)
//   ph_drop      registered pheromone ID to deposit, 0 = none
module ant_ph_tracker
  import ant_nav_ctrl_pkg::*;
#(
  parameter int PH_WIDTH = PH_WIDTH_DEFAULT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                forward_i,
  input  logic                drop_fwd,
  input  logic [PH_WIDTH-1:0] ph_detected,
  output logic                flip_o,
  output logic [PH_WIDTH-1:0] ph_drop
);

  logic [PH_WIDTH-1:0] lap_id;
  logic [PH_WIDTH-1:0] lap_next;

  // Lap ID skips 0 on wrap, since 0 on the floor means "no pheromone".
  assign lap_next = (lap_id == {PH_WIDTH{1'b1}}) ? PH_WIDTH'(1) : lap_id + PH_WIDTH'(1);
  assign flip_o   = forward_i && (ph_detected == lap_id);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lap_id  <= PH_WIDTH'(1);
      ph_drop <= '0;
    end else begin
      if (flip_o) lap_id <= lap_next;
      // The flipping move already marks the floor with the new lap.
      ph_drop <= drop_fwd ? (flip_o ? lap_next : lap_id) : '0;
    end
  end

endmodule

// File: rtl/ant_nav_ctrl.sv
// Maze-navigation controller for the ant agent (wall follower).
// Follows a wall on a selectable side, forces a timed spin when stuck,
// latches a finish on escape and flips the follow side when it crosses
// its own pheromone trail.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   ant_l, ant_r    left/right antenna touch
//   hit             frontal collision
//   escape          exit reached
//   ph_detected     pheromone ID at the current cell
//   ph_drop         registered pheromone ID to deposit
//   move            registered move code (HALT/RIGHT/LEFT/FORWARD)
//   side_left       registered follow side, 1 = left-hand wall
module ant_nav_ctrl
  import ant_nav_ctrl_pkg::*;
#(
  parameter int PH_WIDTH    = PH_WIDTH_DEFAULT,
  parameter bit FOLLOW_LEFT = 1'b1,
  parameter int STUCK_LIMIT = 12,
  parameter int SPIN_CYC    = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ant_l,
  input  logic                ant_r,
  input  logic                hit,
  input  logic                escape,
  input  logic [PH_WIDTH-1:0] ph_detected,
  output logic [PH_WIDTH-1:0] ph_drop,
  output logic [1:0]          move,
  output logic                side_left
);

  localparam logic [7:0] STUCK_MAX = 8'(STUCK_LIMIT);
  localparam logic [7:0] SPIN_LAST = 8'(SPIN_CYC - 1);

  state_t     state, nxt_state;
  move_t      move_q, nxt_move, decided, toward, away;
  logic [7:0] stuck_cnt, nxt_stuck;
  logic [7:0] spin_cnt, nxt_spin;
  logic [8:0] stuck_inc;
  logic       had_wall, nxt_had_wall;
  logic       w, o;
  logic       forward_q, drop_fwd, flip;

  assign w         = side_left ? ant_l : ant_r;
  assign o         = side_left ? ant_r : ant_l;
  assign toward    = side_left ? LEFT : RIGHT;
  assign away      = side_left ? RIGHT : LEFT;
  assign stuck_inc = {1'b0, stuck_cnt} + 9'd1;
  assign move      = move_q;

  ant_ph_tracker #(.PH_WIDTH(PH_WIDTH)) u_ph (
    .clk         (clk),
    .rst_n       (rst_n),
    .forward_i   (forward_q),
    .drop_fwd    (drop_fwd),
    .ph_detected (ph_detected),
    .flip_o      (flip),
    .ph_drop     (ph_drop)
  );

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      move_q    <= HALT;
      stuck_cnt <= '0;
      spin_cnt  <= '0;
      had_wall  <= 1'b0;
      side_left <= FOLLOW_LEFT;
    end else begin
      state     <= nxt_state;
      move_q    <= nxt_move;
      stuck_cnt <= nxt_stuck;
      spin_cnt  <= nxt_spin;
      had_wall  <= nxt_had_wall;
      if (flip) side_left <= ~side_left;
    end
  end

  // Next-state and move decision
  always_comb begin
    nxt_state    = state;
    nxt_move     = HALT;
    nxt_stuck    = stuck_cnt;
    nxt_spin     = spin_cnt;
    nxt_had_wall = had_wall;
    decided      = FORWARD;
    case (state)
      IDLE: begin
        nxt_move  = FORWARD;
        nxt_state = FOLLOW;
      end
      FOLLOW: begin
        nxt_had_wall = w;
        if (hit)            decided = away;
        else if (o && !w)   decided = away;
        else if (w)         decided = FORWARD;
        else if (had_wall)  decided = toward;
        else                decided = FORWARD;

        if (decided == FORWARD) begin
          nxt_move  = FORWARD;
          nxt_stuck = '0;
        end else if (stuck_inc >= 9'(STUCK_LIMIT)) begin
          // Watchdog: the would-be turn becomes the first spin step.
          nxt_move  = away;
          nxt_state = SPIN;
          nxt_stuck = STUCK_MAX;
          nxt_spin  = SPIN_LAST;
        end else begin
          nxt_move  = decided;
          nxt_stuck = stuck_inc[7:0];
          // Only the lost-wall rule turns toward the wall.
          if (decided == toward) nxt_state = CORNER;
        end
      end
      CORNER: begin
        nxt_move     = FORWARD;
        nxt_state    = FOLLOW;
        nxt_had_wall = 1'b0;
        nxt_stuck    = '0;
      end
      SPIN: begin
        nxt_move = away;
        if (spin_cnt == 8'd0) begin
          nxt_state    = FOLLOW;
          nxt_stuck    = '0;
          nxt_had_wall = 1'b0;
        end else begin
          nxt_spin = spin_cnt - 8'd1;
        end
      end
      DONE:    nxt_move  = HALT;
      default: nxt_state = IDLE;
    endcase
    if (escape) begin
      nxt_state = DONE;
      nxt_move  = HALT;
    end
  end

  // Qualifiers handed to the pheromone tracker
  always_comb begin
    drop_fwd  = (nxt_move == FORWARD);
    forward_q = ((state == FOLLOW) || (state == CORNER)) && drop_fwd && !escape;
  end

endmodule

// File: tb/tb_ant_nav_ctrl.sv
module tb_ant_nav_ctrl;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       ant_l, ant_r, hit, escape;
  logic [1:0] ph_detected;
  logic [1:0] ph_drop;
  logic [1:0] move;
  logic       side_left;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [7:0] M_HALT = 8'd0, M_RIGHT = 8'd1, M_LEFT = 8'd2, M_FWD = 8'd3;

  always #5 clk = ~clk;

  ant_nav_ctrl #(
    .PH_WIDTH    (2),
    .FOLLOW_LEFT (1'b1),
    .STUCK_LIMIT (4),
    .SPIN_CYC    (3)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ant_l       (ant_l),
    .ant_r       (ant_r),
    .hit         (hit),
    .escape      (escape),
    .ph_detected (ph_detected),
    .ph_drop     (ph_drop),
    .move        (move),
    .side_left   (side_left)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [7:0] m, input logic [7:0] d, input logic [7:0] s);
    chk({tag, ".move"}, {6'd0, move}, m);
    chk({tag, ".ph_drop"}, {6'd0, ph_drop}, d);
    chk({tag, ".side"}, {7'd0, side_left}, s);
  endtask

  initial begin
    rst_n = 1'b0; ant_l = 1'b0; ant_r = 1'b0; hit = 1'b0; escape = 1'b0;
    ph_detected = 2'd0;
    step(); step();
    chk_out("reset", M_HALT, 8'd0, 8'd1);

    // Wall on the left: straight ahead, dropping lap 1
    ant_l = 1'b1; rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk_out("t1_follow", M_FWD, 8'd1, 8'd1);
    end

    // Wall ends: turn toward, one corner forward, then search forward
    ant_l = 1'b0;
    step(); chk_out("t2_turn", M_LEFT, 8'd0, 8'd1);
    step(); chk_out("t2_corner", M_FWD, 8'd1, 8'd1);
    step(); chk_out("t2_search0", M_FWD, 8'd1, 8'd1);
    step(); chk_out("t2_search1", M_FWD, 8'd1, 8'd1);

    // Held collision: 3 turns, watchdog turn, 3 spin cycles
    ant_l = 1'b1; ant_r = 1'b1; hit = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step();
      chk_out("t3_away", M_RIGHT, 8'd0, 8'd1);
    end
    // Watchdog counter restarted: 3 more turns stay short of a new spin
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t3_after.move", {6'd0, move}, M_RIGHT);
    end
    hit = 1'b0; ant_r = 1'b0;
    step(); chk_out("t3_resume", M_FWD, 8'd1, 8'd1);

    // Loop flips, PH_WIDTH = 2: lap 1 -> 2 -> 3 -> 1
    ph_detected = 2'd1;
    step(); chk_out("t4_flip1", M_FWD, 8'd2, 8'd0);
    ant_l = 1'b0; ant_r = 1'b1; ph_detected = 2'd2;
    step(); chk_out("t4_flip2", M_FWD, 8'd3, 8'd1);
    ant_l = 1'b1; ant_r = 1'b0; ph_detected = 2'd3;
    step(); chk_out("t4_flip3", M_FWD, 8'd1, 8'd0);
    ant_l = 1'b0; ant_r = 1'b1; ph_detected = 2'd3;
    step(); chk_out("t4_other_id", M_FWD, 8'd1, 8'd0);
    ph_detected = 2'd0;
    step(); chk_out("t4_zero_id", M_FWD, 8'd1, 8'd0);

    // Right-hand follow: stall into SPIN, then escape mid-spin
    hit = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk_out("t5_spin", M_LEFT, 8'd0, 8'd0);
    end
    escape = 1'b1;
    step(); chk_out("t5_escape", M_HALT, 8'd0, 8'd0);
    escape = 1'b0; hit = 1'b0; ant_l = 1'b1; ant_r = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_out("t5_done", M_HALT, 8'd0, 8'd0);
    end
    // Asynchronous reset well before the next edge
    #2 rst_n = 1'b0;
    #1 chk_out("t5_async_rst", M_HALT, 8'd0, 8'd1);
    #1 rst_n = 1'b1;
    step(); chk_out("t5_idle_exit", M_FWD, 8'd1, 8'd1);

    // Escape beats a pending loop flip
    ph_detected = 2'd1; escape = 1'b1;
    step(); chk_out("t6_esc_flip", M_HALT, 8'd0, 8'd1);
    escape = 1'b0;
    step(); chk_out("t6_hold", M_HALT, 8'd0, 8'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #20000;
    n_err++;
    $display("FAIL timeout: observed no end expected end");
    $fatal(1, "bench time limit");
  end

endmodule

// File: doc/ant_nav_ctrl.md
Name: ant_nav_ctrl

Overview:
Parametrised maze-navigation controller for the ant agent, the next generation of our wall-follower. It reads the two antennae, the hit flag and the escape flag, and issues one registered move per clock. New over the previous controller:
- selectable and runtime-flippable follow side;
- a stuck watchdog that forces a timed spin;
- a latched finish on escape;
- a pheromone trail of configurable width that detects revisits and flips the follow side to break loops.

Parameters:
PH_WIDTH, 4, width of the pheromone trail ID (ph_drop/ph_detected); a value of 0 means "no pheromone".
FOLLOW_LEFT, 1, initial follow side (1 = left-hand wall, 0 = right-hand wall).
STUCK_LIMIT, 12, number of consecutive non-FORWARD moves that triggers SPIN (legal range 2..255).
SPIN_CYC, 3, number of cycles spent in SPIN (legal range 1..255).

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
ant_l  in  1  left antenna touches wall
ant_r  in  1  right antenna touches wall
hit  in  1  frontal collision
escape  in  1  ant has reached the exit
ph_detected  in  PH_WIDTH  pheromone ID present at the current cell
ph_drop  out  PH_WIDTH  pheromone ID to deposit (registered)
move  out  2  HALT/RIGHT/LEFT/FORWARD codes (registered)
side_left  out  1  current follow side, 1 = left (registered)

Behaviour:
- One clock domain. Reset is asynchronous and active-low.
- Reset values:
  - move = HALT, ph_drop = 0;
  - side_left = FOLLOW_LEFT, lap_id = 1;
  - stuck_cnt = 0, spin_cnt = 0, had_wall = 0;
  - state = IDLE.
- Latency: move and ph_drop are registered. Inputs sampled at edge N determine the outputs after edge N.
- Naming:
  - w = follow-side antenna (ant_l if side_left, else ant_r); o = the opposite antenna.
  - "toward" = LEFT if side_left, else RIGHT; "away" = the other turn.

States:
- IDLE: leaves on the first clock after reset and emits FORWARD. It goes to DONE if escape is high, otherwise to FOLLOW.
- FOLLOW: the next move is chosen by the first rule that matches, in this priority order:
  1. hit = 1 -> away.
  2. o = 1 and w = 0 -> away.
  3. w = 1 -> FORWARD. This covers o = 1 with hit = 0, as in a corridor.
  4. w = 0, o = 0, had_wall = 1 -> toward, and the state goes to CORNER.
  5. w = 0, o = 0, had_wall = 0 -> FORWARD (searching for a wall).
  - had_wall is updated to w every cycle while in FOLLOW.
- CORNER: always emits exactly one FORWARD, then returns to FOLLOW with had_wall cleared. The FORWARD carries the ant around the wall end.
- SPIN:
  - Emits away for SPIN_CYC cycles, ignoring the antennae and hit.
  - On the last cycle, stuck_cnt and had_wall are cleared and the state returns to FOLLOW.
- DONE: move = HALT and ph_drop = 0 permanently. Only rst_n leaves DONE.

Event rules:
- Escape: escape = 1 in any state has top priority. The next state is DONE and the next move is HALT.
- Watchdog:
  - stuck_cnt increments on every non-FORWARD move issued from FOLLOW, saturating at STUCK_LIMIT. It clears on any FORWARD.
  - When the increment would reach STUCK_LIMIT, that cycle's move is replaced by away and the state goes to SPIN.
  - spin_cnt counts from SPIN_CYC-1 down to 0.
- Pheromone:
  - ph_drop = lap_id on every cycle whose next move is FORWARD. Otherwise ph_drop = 0.
  - Loop flip: in FOLLOW or CORNER, if ph_detected == lap_id and the decided move is FORWARD, then side_left toggles and lap_id increments.
    - lap_id wraps from 2^PH_WIDTH-1 to 1 and never takes the value 0.
    - That cycle's move is still FORWARD, and ph_drop carries the new lap_id.
  - ph_detected == 0, or any value not equal to lap_id, has no effect.
- Simultaneous events:
  - escape beats a loop flip, which beats a watchdog trigger.
  - A loop flip and the watchdog cannot coincide, because a flip implies FORWARD.
- Reset mid-operation: all registers return immediately, asynchronously, to their reset values, including DONE -> IDLE.

Decomposition:
- Shared package/defines file holds:
  - the move codes HALT, RIGHT, LEFT, FORWARD;
  - PH_WIDTH_DEFAULT;
  - the state encodings IDLE, FOLLOW, CORNER, SPIN, DONE as a 3-bit enum with distinct values.
- Sub-module ant_ph_tracker owns lap_id, the equality compare, the wrap logic and the ph_drop mux. Its interface is flip_o and the qualified forward_i.
- The FSM, watchdog and move decode remain in ant_nav_ctrl.

Test Plan:
1. Reset, FOLLOW_LEFT = 1, ant_l = 1, ant_r = 0 for 5 cycles -> move: FORWARD from the first edge onward; ph_drop = 1 each cycle; side_left = 1.
2. Follow a wall, then ant_l = 0, ant_r = 0 -> one cycle LEFT, then one cycle FORWARD (CORNER), then back in FOLLOW. With inputs still 00, the ant searches with FORWARD.
3. FOLLOW_LEFT = 1, ant_l = 1, ant_r = 1, hit = 1 held with STUCK_LIMIT = 4 -> RIGHT for 3 cycles, then a 4th RIGHT entering SPIN. Then 3 RIGHT in SPIN with hit ignored, then FOLLOW and stuck_cnt = 0.
4. Forward with lap_id = 1 and ph_detected = 1 -> side_left goes 1 -> 0 and ph_drop = 2 the same cycle. With PH_WIDTH = 2, repeat the flip 3 times -> lap_id sequence is 2, 3, 1 and 0 never appears.
5. escape pulsed for 1 cycle in SPIN -> move = HALT and ph_drop = 0 from the next edge, held indefinitely. Asserting rst_n low mid-DONE forces move = HALT and state IDLE asynchronously, before the next edge.
6. Same cycle: escape = 1 and ph_detected == lap_id while forward -> DONE and HALT; side_left unchanged; lap_id unchanged.
